spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Bus-master sequencer that drives the SoC SPI core's register port to perform serial-flash READ (0x03) transactions without CPU involvement. A requester supplies a 24-bit flash address and byte count. The block then:
- asserts chip-select,
- shifts out the command and address,
- clocks in the requested bytes, streaming each to the requester,
- releases chip-select.

It sits between a boot/XIP loader and the SPI core, on the same wishbone-style port the AHB glue uses.

## Interface
Parameters:
- LEN_W, 16, width of byte-count input
- CMD, 8'h03, flash read opcode sent first
- POLL_MAX, 255, max status polls per byte before timeout error

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req_i  in  1  start pulse; sampled only in IDLE
- addr_i  in  24  flash start address, captured with req_i
- len_i  in  LEN_W  bytes to read, captured with req_i
- abort_i  in  1  level; request early termination
- busy_o  out  1  high from accepted req_i until done_o
- done_o  out  1  one-cycle pulse at end of transaction
- err_o  out  1  valid with done_o; 1 = aborted or poll timeout
- rdata_o  out  8  received flash byte
- rvalid_o  out  1  one-cycle pulse, rdata_o valid
- cyc_o, stb_o  out  1  bus cycle/strobe, always equal
- adr_o  out  2  SPI core register select
- we_o  out  1  write enable
- dat_o  out  32  write data (upper 24 bits zero)
- dat_i  in  32  read data from SPI core
- ack_i  in  1  bus acknowledge from SPI core

## Operation
SPI core register map:
- 0 CTRL: bit0 = 1 asserts scs.
- 1 STATUS: bit0 = transfer busy.
- 2 DATA: write starts an 8-bit exchange; read returns the last received byte.

States:
- IDLE: on req_i with len_i != 0, capture addr_i/len_i, raise busy_o, go to CS_ON. On req_i with len_i == 0, pulse done_o (err_o = 0) next cycle, no bus activity, remain IDLE.
- CS_ON: write CTRL = 1, then go to TX.
- TX: write DATA. Byte sequence is CMD, addr[23:16], addr[15:8], addr[7:0], then 0x00 per payload byte. Then go to POLL.
- POLL: read STATUS.
  - bit0 = 1: increment poll counter and repeat POLL.
  - Counter reaching POLL_MAX with bit0 still 1: set error, go to CS_OFF.
  - bit0 = 0: clear counter, go to RX.
- RX: read DATA.
  - Header bytes (first 4): discard.
  - Payload bytes: drive rdata_o = dat_i[7:0] and pulse rvalid_o in the cycle after ack_i.
  - Then go to TX, or to CS_OFF if the payload count is exhausted.
- CS_OFF: write CTRL = 0, then go to DONE.
- DONE: pulse done_o with err_o, drop busy_o, go to IDLE.

Counters:
- Header index is 2 bits, 0..3.
- Payload down-counter is LEN_W bits. No wrap: with len_i = all-ones, exactly 2^LEN_W−1 bytes are read.

abort_i:
- Sampled at each ack_i.
- If high in CS_ON/TX/POLL/RX, the current access completes, then the block goes to CS_OFF with error set.
- Ignored in IDLE, CS_OFF, DONE.
- Chip-select is always released before done_o.

## Timing
- Reset values:
  - cyc_o/stb_o/we_o/busy_o/done_o/err_o/rvalid_o = 0.
  - adr_o = 0, dat_o = 0, rdata_o = 0.
  - State = IDLE.
- Bus access protocol:
  - cyc_o/stb_o/adr_o/we_o/dat_o are registered and asserted the cycle after state entry.
  - They are held stable until ack_i is sampled high.
  - cyc_o/stb_o then drop for exactly one cycle before the next access.
  - Minimum access = 2 cycles + 1 gap.
- ack_i while cyc_o is low is ignored.
- busy_o rises the cycle after accepted req_i.
- done_o falls together with busy_o.
- req_i while busy_o is high is ignored.
- rvalid_o fires at most once per 3 bus accesses, so no backpressure is needed.
- Asynchronous reset mid-transaction:
  - All outputs return to reset values immediately; cyc_o drops without waiting for ack_i.
  - scs state inside the SPI core is not restored by this block.

## Test plan
- addr = 0x123456, len = 2, SPI model always not-busy, returns 0xA5, 0x5A:
  - Writes seen: CTRL = 1, DATA = 03, 12, 34, 56, 00, 00, CTRL = 0.
  - rvalid_o twice with 0xA5, 0x5A; done_o with err_o = 0.
- Same transaction with STATUS busy for 5 polls per byte -> exactly 6 STATUS reads per byte, data identical, err_o = 0.
- POLL_MAX = 4, STATUS stuck busy -> after the CMD byte, 4 polls then CTRL = 0; done_o with err_o = 1; no rvalid_o.
- len = 0 -> done_o one cycle after req_i, err_o = 0, cyc_o never asserted.
- abort_i raised during the 2nd payload TX of len = 8 -> current access completes, then CTRL = 0; done_o with err_o = 1; exactly 1 rvalid_o.
- HRESETn pulsed low while cyc_o is high in POLL -> all outputs zero same cycle; new req_i after release runs a clean transaction.

Source files
------------

// File: rtl/spi_flash_reader.sv
// Bus-master sequencer: drives the SPI core register port to perform a serial-flash
// READ (command, 24-bit address, N payload bytes) and streams received bytes out.
//
// state  | meaning
// IDLE   | waiting for req_i
// CS_ON  | write CTRL = 1 (assert chip-select)
// TX     | write DATA (command/address byte, or 0x00 dummy per payload byte)
// POLL   | read STATUS until the exchange finishes or the poll budget runs out
// RX     | read DATA; header bytes discarded, payload bytes streamed out
// CS_OFF | write CTRL = 0 (release chip-select)
// DONE   | pulse done_o with err_o, drop busy_o
module spi_flash_reader #(
  parameter int         LEN_W    = 16,
  parameter logic [7:0] CMD      = 8'h03,
  parameter int         POLL_MAX = 255
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             req_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       rdata_o,
  output logic             rvalid_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic [1:0]       adr_o,
  output logic             we_o,
  output logic [31:0]      dat_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [1:0] ADR_CTRL = 2'd0, ADR_STATUS = 2'd1, ADR_DATA = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_ON, S_TX, S_POLL, S_RX, S_CS_OFF, S_DONE
  } state_t;

  state_t           state_q;
  logic             cyc_q, we_q, busy_q, done_q, err_q, rvalid_q;
  logic [1:0]       adr_q;
  logic [7:0]       dat_q, rdata_q, tx_byte;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic             hdr_q;
  logic [1:0]       hdr_idx_q;
  logic [PW-1:0]    poll_q;
  logic             unused_dat;

  assign unused_dat = ^dat_i[31:8];

  always_comb begin
    tx_byte = 8'h00;
    if (hdr_q) begin
      case (hdr_idx_q)
        2'd0:    tx_byte = CMD;
        2'd1:    tx_byte = addr_q[23:16];
        2'd2:    tx_byte = addr_q[15:8];
        default: tx_byte = addr_q[7:0];
      endcase
    end
  end

  // Each bus state: first cycle issues the access, then hold until ack_i.
  // Clearing cyc_q on ack gives the mandatory one-cycle gap on the next entry.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 2'd0;
      dat_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
      addr_q    <= 24'h0;
      rem_q     <= '0;
      hdr_q     <= 1'b0;
      hdr_idx_q <= 2'd0;
      poll_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      if (cyc_q && ack_i) cyc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            err_q <= 1'b0;
            if (len_i != '0) begin
              addr_q    <= addr_i;
              rem_q     <= len_i;
              hdr_q     <= 1'b1;
              hdr_idx_q <= 2'd0;
              poll_q    <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_CS_ON;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_CS_ON: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1; adr_q <= ADR_CTRL; we_q <= 1'b1; dat_q <= 8'h01;
          end else if (ack_i) begin
            if (abort_i) err_q <= 1'b1;
            state_q <= abort_i ? S_CS_OFF : S_TX;
          end
        end
        S_TX: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1; adr_q <= ADR_DATA; we_q <= 1'b1; dat_q <= tx_byte;
          end else if (ack_i) begin
            if (abort_i) err_q <= 1'b1;
            state_q <= abort_i ? S_CS_OFF : S_POLL;
          end
        end
        S_POLL: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1; adr_q <= ADR_STATUS; we_q <= 1'b0;
          end else if (ack_i) begin
            if (abort_i) begin
              err_q   <= 1'b1;
              poll_q  <= '0;
              state_q <= S_CS_OFF;
            end else if (dat_i[0]) begin
              if (poll_q == POLL_LAST) begin
                err_q   <= 1'b1;
                poll_q  <= '0;
                state_q <= S_CS_OFF;
              end else begin
                poll_q <= poll_q + PW'(1);
              end
            end else begin
              poll_q  <= '0;
              state_q <= S_RX;
            end
          end
        end
        S_RX: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1; adr_q <= ADR_DATA; we_q <= 1'b0;
          end else if (ack_i) begin
            if (hdr_q) begin
              hdr_idx_q <= hdr_idx_q + 2'd1;
              if (hdr_idx_q == 2'd3) hdr_q <= 1'b0;
            end else begin
              rdata_q  <= dat_i[7:0];
              rvalid_q <= 1'b1;
              rem_q    <= rem_q - LEN_W'(1);
            end
            if (abort_i) begin
              err_q   <= 1'b1;
              state_q <= S_CS_OFF;
            end else if (!hdr_q && rem_q == LEN_W'(1)) begin
              state_q <= S_CS_OFF;
            end else begin
              state_q <= S_TX;
            end
          end
        end
        S_CS_OFF: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1; adr_q <= ADR_CTRL; we_q <= 1'b1; dat_q <= 8'h00;
          end else if (ack_i) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign adr_o    = adr_q;
  assign we_o     = we_q;
  assign dat_o    = {24'h0, dat_q};

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: a small SPI-core register model answers bus
// accesses, logs writes and records streamed bytes; each task checks one scenario.
module tb_spi_flash_reader;
  localparam int LEN_W    = 16;
  localparam int POLL_MAX = 6;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             req_i = 1'b0;
  logic [23:0]      addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             abort_i = 1'b0;
  logic             busy_o, done_o, err_o, rvalid_o, cyc_o, stb_o, we_o;
  logic [7:0]       rdata_o;
  logic [1:0]       adr_o;
  logic [31:0]      dat_o;
  logic [31:0]      dat_i = '0;
  logic             ack_i = 1'b0;

  spi_flash_reader #(.LEN_W(LEN_W), .CMD(8'h03), .POLL_MAX(POLL_MAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .adr_o(adr_o), .we_o(we_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  int busy_per_byte, busy_left, abort_at;
  bit stuck, last_err, hi_bits, stb_mismatch;
  int data_reads, data_writes, stat_reads, rv_cnt, done_cnt, cyc_cnt;
  logic [7:0] payload [8];
  logic [7:0] rv_bytes [$];
  int wr_log [$];

  // SPI core model: acks every access one cycle after cyc_o rises.
  always @(negedge HCLK) begin
    if (!HRESETn) ack_i = 1'b0;
    else if (ack_i) ack_i = 1'b0;
    else if (cyc_o) begin
      cyc_cnt++;
      if (dat_o[31:8] != 24'h0) hi_bits = 1'b1;
      if (we_o) begin
        wr_log.push_back(int'({adr_o, dat_o[7:0]}));
        if (adr_o == 2'd2) begin
          data_writes++;
          busy_left = busy_per_byte;
          if (abort_at != 0 && data_writes == abort_at) abort_i = 1'b1;
        end
      end else if (adr_o == 2'd1) begin
        stat_reads++;
        dat_i = {31'h0, (stuck || busy_left > 0)};
        if (busy_left > 0) busy_left--;
      end else begin
        dat_i = {24'h0, (data_reads >= 4 && data_reads < 12) ? payload[data_reads-4] : 8'hEE};
        data_reads++;
      end
      ack_i = 1'b1;
    end
    if (cyc_o !== stb_o) stb_mismatch = 1'b1;
    if (rvalid_o) begin rv_cnt++; rv_bytes.push_back(rdata_o); end
    if (done_o) begin done_cnt++; last_err = err_o; end
  end

  task automatic clear_model();
    busy_per_byte = 0; busy_left = 0; abort_at = 0; stuck = 0; abort_i = 1'b0;
    hi_bits = 0; stb_mismatch = 0; last_err = 0;
    data_reads = 0; data_writes = 0; stat_reads = 0; rv_cnt = 0; done_cnt = 0; cyc_cnt = 0;
    rv_bytes.delete(); wr_log.delete();
    for (int i = 0; i < 8; i++) payload[i] = 8'h00;
  endtask

  task automatic start_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
    @(negedge HCLK);
    req_i = 1'b1; addr_i = a; len_i = l;
    @(negedge HCLK);
    req_i = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output bit busy_at);
    seen = 0; busy_at = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge HCLK);
      if (done_o) begin seen = 1; busy_at = busy_o; end
    end
  endtask

  task automatic test_reset();
    logic [48:0] v;
    @(negedge HCLK);
    v = {cyc_o, stb_o, we_o, busy_o, done_o, err_o, rvalid_o, adr_o, dat_o, rdata_o};
    n_checks++;
    if (v !== 49'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", v); end
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    v = {cyc_o, stb_o, we_o, busy_o, done_o, err_o, rvalid_o, adr_o, dat_o, rdata_o};
    n_checks++;
    if (v !== 49'h0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 0", v); end
  endtask

  task automatic test_basic_read();
    int exp_wr [$] = '{'h001, 'h203, 'h212, 'h234, 'h256, 'h200, 'h200, 'h000};
    bit seen, busy_at, ok;
    clear_model();
    payload[0] = 8'hA5; payload[1] = 8'h5A;
    start_req(24'h123456, 16'd2);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy_o); end
    wait_done(seen, busy_at);
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL basic_done: got no done_o expected done_o"); end
    n_checks++;
    if (busy_at !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 1", busy_at); end
    @(negedge HCLK);
    n_checks++;
    if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL basic_busy_done_fall: got %b expected 00", {busy_o, done_o}); end
    n_checks++;
    if (last_err !== 1'b0 || done_cnt != 1) begin n_fail++; $display("FAIL basic_err: got err=%b dones=%0d expected err=0 dones=1", last_err, done_cnt); end
    ok = (wr_log.size() == exp_wr.size());
    foreach (exp_wr[i]) if (ok && wr_log[i] != exp_wr[i]) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_writes: got %0d writes expected CTRL1,03,12,34,56,00,00,CTRL0", wr_log.size()); end
    n_checks++;
    if (rv_cnt != 2 || rv_bytes.size() != 2) begin n_fail++; $display("FAIL basic_rvalid_count: got %0d expected 2", rv_cnt); end
    else if (rv_bytes[0] !== 8'hA5 || rv_bytes[1] !== 8'h5A) begin
      n_fail++; $display("FAIL basic_rdata: got %h %h expected a5 5a", rv_bytes[0], rv_bytes[1]);
    end
    n_checks++;
    if (stat_reads != 6) begin n_fail++; $display("FAIL basic_status_reads: got %0d expected 6", stat_reads); end
    n_checks++;
    if (hi_bits || stb_mismatch) begin n_fail++; $display("FAIL basic_bus_shape: got hi=%b stb_diff=%b expected 0 0", hi_bits, stb_mismatch); end
  endtask

  task automatic test_poll_busy();
    bit seen, busy_at;
    clear_model();
    busy_per_byte = 5;
    payload[0] = 8'hA5; payload[1] = 8'h5A;
    start_req(24'h123456, 16'd2);
    wait_done(seen, busy_at);
    @(negedge HCLK);
    n_checks++;
    if (!seen || last_err !== 1'b0) begin n_fail++; $display("FAIL busy_done_err: got seen=%b err=%b expected 1 0", seen, last_err); end
    n_checks++;
    if (stat_reads != 36) begin n_fail++; $display("FAIL busy_status_reads: got %0d expected 36", stat_reads); end
    n_checks++;
    if (rv_bytes.size() != 2) begin n_fail++; $display("FAIL busy_rvalid_count: got %0d expected 2", rv_bytes.size()); end
    else if (rv_bytes[0] !== 8'hA5 || rv_bytes[1] !== 8'h5A) begin
      n_fail++; $display("FAIL busy_rdata: got %h %h expected a5 5a", rv_bytes[0], rv_bytes[1]);
    end
  endtask

  task automatic test_poll_timeout();
    int exp_wr [$] = '{'h001, 'h203, 'h000};
    bit seen, busy_at, ok;
    clear_model();
    stuck = 1;
    start_req(24'h123456, 16'd2);
    wait_done(seen, busy_at);
    @(negedge HCLK);
    n_checks++;
    if (!seen || last_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got seen=%b err=%b expected 1 1", seen, last_err); end
    n_checks++;
    if (stat_reads != POLL_MAX) begin n_fail++; $display("FAIL timeout_polls: got %0d expected %0d", stat_reads, POLL_MAX); end
    ok = (wr_log.size() == exp_wr.size());
    foreach (exp_wr[i]) if (ok && wr_log[i] != exp_wr[i]) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_writes: got %0d writes expected CTRL1,03,CTRL0", wr_log.size()); end
    n_checks++;
    if (rv_cnt != 0) begin n_fail++; $display("FAIL timeout_rvalid: got %0d expected 0", rv_cnt); end
    stuck = 0;
  endtask

  task automatic test_zero_len();
    clear_model();
    @(negedge HCLK);
    req_i = 1'b1; addr_i = 24'hFFFFFF; len_i = '0;
    @(negedge HCLK);
    req_i = 1'b0;
    n_checks++;
    if ({done_o, err_o, busy_o} !== 3'b100) begin n_fail++; $display("FAIL zero_done_pulse: got %b expected 100", {done_o, err_o, busy_o}); end
    @(negedge HCLK);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b expected 0", done_o); end
    repeat (5) @(negedge HCLK);
    n_checks++;
    if (cyc_cnt != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_no_bus: got cyc=%0d busy=%b expected 0 0", cyc_cnt, busy_o); end
  endtask

  task automatic test_abort();
    int exp_wr [$] = '{'h001, 'h203, 'h212, 'h234, 'h256, 'h200, 'h200, 'h000};
    bit seen, busy_at, ok;
    clear_model();
    for (int i = 0; i < 8; i++) payload[i] = 8'h10 + 8'(i);
    abort_at = 6;
    start_req(24'h123456, 16'd8);
    wait_done(seen, busy_at);
    @(negedge HCLK);
    abort_i = 1'b0;
    n_checks++;
    if (!seen || last_err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got seen=%b err=%b expected 1 1", seen, last_err); end
    n_checks++;
    if (rv_bytes.size() != 1) begin n_fail++; $display("FAIL abort_rvalid_count: got %0d expected 1", rv_bytes.size()); end
    else if (rv_bytes[0] !== 8'h10) begin n_fail++; $display("FAIL abort_rdata: got %h expected 10", rv_bytes[0]); end
    ok = (wr_log.size() == exp_wr.size());
    foreach (exp_wr[i]) if (ok && wr_log[i] != exp_wr[i]) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_writes: got %0d writes expected CTRL1,03,12,34,56,00,00,CTRL0", wr_log.size()); end
    n_checks++;
    if (data_reads != 5) begin n_fail++; $display("FAIL abort_data_reads: got %0d expected 5", data_reads); end
  endtask

  task automatic test_reset_mid();
    logic [48:0] v;
    bit seen, busy_at, hit;
    clear_model();
    busy_per_byte = 3;
    start_req(24'h123456, 16'd2);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge HCLK);
      if (cyc_o && adr_o == 2'd1 && !we_o) hit = 1;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL rstmid_poll_seen: got no STATUS access expected one"); end
    #2 HRESETn = 1'b0;
    #1;
    v = {cyc_o, stb_o, we_o, busy_o, done_o, err_o, rvalid_o, adr_o, dat_o, rdata_o};
    n_checks++;
    if (v !== 49'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h expected 0", v); end
    @(negedge HCLK);
    ack_i = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    clear_model();
    payload[0] = 8'hC3; payload[1] = 8'h3C;
    start_req(24'h000102, 16'd2);
    wait_done(seen, busy_at);
    @(negedge HCLK);
    n_checks++;
    if (!seen || last_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_rerun: got seen=%b err=%b expected 1 0", seen, last_err); end
    n_checks++;
    if (rv_bytes.size() != 2) begin n_fail++; $display("FAIL rstmid_rvalid: got %0d expected 2", rv_bytes.size()); end
    else if (rv_bytes[0] !== 8'hC3 || rv_bytes[1] !== 8'h3C) begin
      n_fail++; $display("FAIL rstmid_rdata: got %h %h expected c3 3c", rv_bytes[0], rv_bytes[1]);
    end
  endtask

  task automatic test_back_to_back();
    int exp_wr [$] = '{'h001, 'h203, 'h2AB, 'h2CD, 'h2EF, 'h200, 'h000};
    bit seen, busy_at, ok;
    clear_model();
    payload[0] = 8'h7E;
    start_req(24'hABCDEF, 16'd1);
    @(negedge HCLK);
    req_i = 1'b1; addr_i = 24'h0; len_i = '0;
    @(negedge HCLK);
    req_i = 1'b0;
    wait_done(seen, busy_at);
    repeat (4) @(negedge HCLK);
    n_checks++;
    if (!seen || done_cnt != 1 || last_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ignored_req: got dones=%0d err=%b expected 1 0", done_cnt, last_err);
    end
    ok = (wr_log.size() == exp_wr.size());
    foreach (exp_wr[i]) if (ok && wr_log[i] != exp_wr[i]) ok = 0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_writes: got %0d writes expected CTRL1,03,AB,CD,EF,00,CTRL0", wr_log.size()); end
    n_checks++;
    if (rv_bytes.size() != 1 || rv_bytes[0] !== 8'h7E) begin
      n_fail++; $display("FAIL b2b_rdata: got %0d bytes expected one byte 7e", rv_bytes.size());
    end
    payload[0] = 8'h99;
    clear_model();
    payload[0] = 8'h99;
    start_req(24'h000010, 16'd1);
    wait_done(seen, busy_at);
    @(negedge HCLK);
    n_checks++;
    if (!seen || rv_bytes.size() != 1 || rv_bytes[0] !== 8'h99) begin
      n_fail++; $display("FAIL b2b_second: got seen=%b bytes=%0d expected 1 1", seen, rv_bytes.size());
    end
  endtask

  initial begin
    clear_model();
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    test_reset();
    test_basic_read();
    test_poll_busy();
    test_poll_timeout();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
